// File: rtl/mem_port_arbiter.sv
// Three-port arbiter in front of one single-port memory: one transaction at a time,
// fixed priority data > fetch > ext, with a starvation override for the ext port.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic [2:0]              req_valid_in,
  output logic [2:0]              req_ready_out,
  input  logic [2:0]              req_we_in,
  input  logic [3*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [3*DATA_WIDTH-1:0] req_wdata_in,
  output logic [2:0]              rsp_valid_out,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic                    mem_en_out,
  output logic                    mem_we_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_wdata_out,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
  output logic                    busy_out,
  output logic [1:0]              owner_out
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);
  localparam logic [1:0] WAIT_INIT = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic [SC_W-1:0]       starve_q, starve_d;
  logic [1:0]            owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [2:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  busy_q, busy_d;

  logic                  arb_en_s;
  logic [2:0]            grant_s;
  logic [1:0]            sel_idx_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  // Ready must read 0 while reset is held, and no new accept may coincide with the
  // completion strobe of the previous transaction.
  assign arb_en_s = reset_in & (rsp_valid_q == 3'b000);

  always_comb begin
    grant_s   = 3'b000;
    sel_idx_s = 2'd0;
    if ((state_q == S_IDLE) && arb_en_s) begin
      if ((starve_q == SC_MAX) && req_valid_in[2]) begin
        grant_s   = 3'b100;
        sel_idx_s = 2'd2;
      end else if (req_valid_in[1]) begin
        grant_s   = 3'b010;
        sel_idx_s = 2'd1;
      end else if (req_valid_in[0]) begin
        grant_s   = 3'b001;
        sel_idx_s = 2'd0;
      end else if (req_valid_in[2]) begin
        grant_s   = 3'b100;
        sel_idx_s = 2'd2;
      end else begin
        grant_s   = 3'b000;
        sel_idx_s = 2'd0;
      end
    end else begin
      grant_s   = 3'b000;
      sel_idx_s = 2'd0;
    end
  end

  always_comb begin
    sel_we_s    = req_we_in[0];
    sel_addr_s  = req_addr_in[0 +: ADDR_WIDTH];
    sel_wdata_s = req_wdata_in[0 +: DATA_WIDTH];
    case (sel_idx_s)
      2'd1: begin
        sel_we_s    = req_we_in[1];
        sel_addr_s  = req_addr_in[ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = req_wdata_in[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_we_s    = req_we_in[2];
        sel_addr_s  = req_addr_in[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = req_wdata_in[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        sel_we_s    = req_we_in[0];
        sel_addr_s  = req_addr_in[0 +: ADDR_WIDTH];
        sel_wdata_s = req_wdata_in[0 +: DATA_WIDTH];
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    rsp_valid_d = 3'b000;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s != 3'b000) begin
          state_d  = S_ISSUE;
          owner_d  = sel_idx_s;
          we_d     = sel_we_s;
          addr_d   = sel_addr_s;
          wdata_d  = sel_wdata_s;
          mem_en_d = 1'b1;
          mem_we_d = sel_we_s;
          // Port 2 counts a lost grant only while it is actually waiting.
          if (grant_s[2]) begin
            starve_d = '0;
          end else if (req_valid_in[2]) begin
            starve_d = (starve_q == SC_MAX) ? SC_MAX : (starve_q + SC_ONE);
          end else begin
            starve_d = '0;
          end
        end else if (!req_valid_in[2]) begin
          starve_d = '0;
        end else begin
          starve_d = starve_q;
        end
      end
      S_ISSUE: begin
        if (MEM_LATENCY == 1) begin
          state_d = S_RESP;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        // Memory data is valid in this cycle; the strobe and data appear together next cycle.
        state_d     = S_IDLE;
        rsp_valid_d = 3'b001 << owner_q;
        if (!we_q) begin
          rsp_rdata_d = mem_rdata_in;
        end else begin
          rsp_rdata_d = rsp_rdata_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 2'd0;
      starve_q    <= '0;
      owner_q     <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 3'b000;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready_out = grant_s;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_rdata_out = rsp_rdata_q;
  assign mem_en_out    = mem_en_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = addr_q;
  assign mem_wdata_out = wdata_q;
  assign busy_out      = busy_q;
  assign owner_out     = owner_q;

endmodule
